// File: rtl/bcd_to_binary_pkg.sv
// Shared constants and state encoding for the BCD-to-binary converter.
// Also holds the digit limits used by the adjust step.
package bcd_to_binary_pkg;

  localparam int unsigned DefDigits = 4;
  localparam int unsigned DefBinW   = 14;

  localparam logic [3:0] DigitMax  = 4'd9;
  localparam logic [3:0] AdjThresh = 4'd8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StShift = 3'd2,
    StSub3  = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/bcd_sub3_adjust.sv
// One BCD nibble of the reverse double-dabble correction step.
// The nibble drops by 3 once a shift has pushed it to 8 or more.
module bcd_sub3_adjust
  import bcd_to_binary_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= AdjThresh) ? (nib_i - 4'd3) : nib_i;

endmodule

// File: rtl/bcd_to_binary.sv
// Multi-cycle packed-BCD to binary converter (reverse double-dabble).
// Start/ready handshake; digits above 9 are flagged instead of converted.
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int unsigned Digits = DefDigits,
  parameter int unsigned BinW   = DefBinW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [4*Digits-1:0]   bcd_i,
  output logic [BinW-1:0]       binary_o,
  output logic                  error_o,
  output logic                  ready_o
);

  localparam int unsigned BcdW = 4 * Digits;
  localparam int unsigned RegW = BcdW + BinW;
  localparam int unsigned CntW = $clog2(BinW + 1);

  state_e          state_q, state_d;
  logic [RegW-1:0] work_q, work_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BinW-1:0] binary_q, binary_d;
  logic            error_q, error_d;

  logic [BcdW-1:0] adj_bcd;
  logic [RegW-1:0] shifted;
  logic            bad_digit;
  logic            last_shift;

  assign shifted    = work_q >> 1;
  assign last_shift = (cnt_q == CntW'(1));

  for (genvar g = 0; g < Digits; g++) begin : g_adj
    bcd_sub3_adjust u_adj (
      .nib_i (work_q[BinW + 4*g +: 4]),
      .nib_o (adj_bcd[4*g +: 4])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < Digits; i++) begin
      if (bcd_i[4*i +: 4] > DigitMax) bad_digit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StLoad;
      StLoad:  state_d = bad_digit ? StDone : StShift;
      StShift: state_d = last_shift ? StDone : StSub3;
      StSub3:  state_d = StShift;
      StDone:  if (!start_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state; binary/error only move in LOAD and on the final shift.
  always_comb begin
    work_d   = work_q;
    cnt_d    = cnt_q;
    binary_d = binary_q;
    error_d  = error_q;
    unique case (state_q)
      StLoad: begin
        work_d  = {bcd_i, {BinW{1'b0}}};
        cnt_d   = CntW'(BinW);
        error_d = bad_digit;
        if (bad_digit) binary_d = '0;
      end
      StShift: begin
        work_d = shifted;
        cnt_d  = cnt_q - CntW'(1);
        if (last_shift) binary_d = shifted[BinW-1:0];
      end
      StSub3: work_d = {adj_bcd, work_q[BinW-1:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q   <= '0;
      cnt_q    <= '0;
      binary_q <= '0;
      error_q  <= 1'b0;
    end else begin
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      binary_q <= binary_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    ready_o  = (state_q == StDone);
    binary_o = binary_q;
    error_o  = error_q;
  end

endmodule
